ram_arbiter_2p: RTL
===================

Name: ram_arbiter_2p

Overview:
- Round-robin arbiter and sequencer sharing the single-port 256x8 data RAM between two requesters: m0 (CPU core data port) and m1 (UART text streamer).
- Drives the RAM's ce/oce/wre/ad/din controls and returns read data with a fixed latency.
- Handles the RAM's one-cycle synchronous read (bypass output) so requesters see a simple req/ack + rvalid protocol.

Parameters:
ADDR_W, 8, RAM address width (256 locations)
DATA_W, 8, RAM data width
READ_LATENCY, 1, cycles from RAM capture edge to valid dout; legal range 1..3

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  m0 request; m0_we/m0_addr/m0_wdata held stable while m0_req=1 and m0_ack=0
m0_we  in  1  1=write, 0=read
m0_addr  in  ADDR_W  m0 address
m0_wdata  in  DATA_W  m0 write data
m0_ack  out  1  request accepted this cycle (combinational)
m0_rvalid  out  1  one-cycle pulse, rdata holds m0's read result
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid  same as m0, for m1
rdata  out  DATA_W  shared read-data register
ram_ce  out  1  RAM clock enable (registered)
ram_oce  out  1  tied 1
ram_wre  out  1  RAM write enable (registered)
ram_ad  out  ADDR_W  RAM address (registered)
ram_din  out  DATA_W  RAM write data (registered)
ram_dout  in  DATA_W  RAM read data

Behaviour:
- Reset (async, immediate): state=IDLE; ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0; rdata=0; m0/m1_rvalid=0; acks=0; last_grant=m1, so m0 wins the first tie. ram_oce=1 always.
- Handshake: a transfer occurs in the cycle where mX_req=1 and mX_ack=1. Requester may change or drop its signals in the next cycle. ack is only ever asserted in IDLE, and to at most one master per cycle.
- Arbitration in IDLE:
  - Only one master requesting: that master is acked.
  - Both requesting: the master that was not last_grant is acked, and last_grant is updated.
  - A master that wins while the other is idle also updates last_grant.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE with ack: register ram_ad/ram_din/ram_wre from the winner, set ram_ce=1, remember the winner and op type, go to ISSUE.
  - ISSUE (1 cycle): ram_ce=1, ram_wre=we, so the RAM captures at the end of this cycle. Next edge: ram_ce=0, ram_wre=0. Write goes to IDLE; read goes to WAIT with cnt=READ_LATENCY-1.
  - WAIT: if cnt=0, rdata<=ram_dout, pulse winner's rvalid next cycle, go to IDLE; else decrement cnt.
- Timing (READ_LATENCY=1):
  - Read: ack at T, ram_ce high at T+1, rvalid+rdata at T+3. A new ack is allowed at T+3, so one read per 3 cycles.
  - Write: ack at T, write at T+1, next ack at T+2.
- rvalid and a new ack may coincide in the same cycle. rdata holds its value until the next read completes.
- Busy: in ISSUE/WAIT both acks are 0 regardless of req. Pending reqs are arbitrated in the next IDLE cycle.
- Address is not modified; ADDR_W bits map directly, so 0xFF is a valid final location with no wrap logic.
- Reset mid-operation: in-flight op is abandoned, no rvalid is ever issued for it. A write aborted in ISSUE is not guaranteed to have updated RAM.
- Requester dropping req before ack: the request is withdrawn, no side effect.

Test Plan:
- Reset then m1 read addr 0x00 acked at T -> m1_rvalid=1 only at T+3, rdata=0x68; m0_rvalid stays 0. Read 0x0B -> 0x0A.
- m0 write 0x10<-0xA5 (ack T), then m0 read 0x10 -> second ack at T+2, rvalid at T+5 with rdata=0xA5; ram_wre high only in T+1.
- m0 and m1 both hold reads continuously after reset -> acks alternate m0,m1,m0,m1; each rvalid goes to the matching master, with rdata from the correct address.
- m1 read in flight (WAIT), m0_req raised -> m0_ack=0 until the IDLE cycle where m1_rvalid=1, then m0_ack=1 in that same cycle.
- reset asserted during WAIT -> ram_ce=0 and state IDLE immediately, no rvalid after deassert, the next request completes normally.
- Write 0xFF<-0x3C then read 0xFF and 0x00 -> 0x3C and 0x68 (no aliasing at top address).

Source files
------------

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous RAM between two
// requesters, exposing a req/ack handshake plus a fixed-latency rvalid/rdata return.
module ram_arbiter_2p #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t     state, state_nxt;
    logic       last_grant;  // 0 = m0, 1 = m1
    logic       op_we;
    logic       op_master;
    logic [1:0] cnt;

    assign ram_oce = 1'b1;

    // Grants are only offered from IDLE; on a tie the master not served last wins.
    always_comb begin
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_req && (!m1_req || last_grant))
                    m0_ack = 1'b1;
                else if (m1_req)
                    m1_ack = 1'b1;
                if (m0_ack || m1_ack)
                    state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = op_we ? IDLE : WAIT;
            WAIT:    if (cnt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_we      <= 1'b0;
            op_master  <= 1'b0;
            cnt        <= 2'd0;
            ram_ce     <= 1'b0;
            ram_wre    <= 1'b0;
            ram_ad     <= '0;
            ram_din    <= '0;
            rdata      <= '0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_ack || m1_ack) begin
                        ram_ce     <= 1'b1;
                        ram_wre    <= m1_ack ? m1_we    : m0_we;
                        ram_ad     <= m1_ack ? m1_addr  : m0_addr;
                        ram_din    <= m1_ack ? m1_wdata : m0_wdata;
                        op_we      <= m1_ack ? m1_we    : m0_we;
                        op_master  <= m1_ack;
                        last_grant <= m1_ack;
                    end
                end
                ISSUE: begin
                    // RAM captures at the end of ISSUE; dout follows READ_LATENCY edges later.
                    ram_ce  <= 1'b0;
                    ram_wre <= 1'b0;
                    cnt     <= 2'(READ_LATENCY - 1);
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        rdata     <= ram_dout;
                        m0_rvalid <= !op_master;
                        m1_rvalid <= op_master;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
